// File: rtl/shifter_prefetch_queue_if.sv
// Bus bundle between the upstream FIFO, the prefetch queue and the shifter.
// The slave modport is the prefetch queue's view of the bundle.
// The master modport is the environment's view: upstream FIFO plus consumer.
interface shifter_prefetch_queue_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          flush;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          pref_rd;
    logic [DW-1:0] pref_data;
    logic          pref_valid;
    logic [LW-1:0] level;
    logic          ovf_err;

    modport slave (
        input  flush, fifo_data, fifo_valid, fifo_empty, pref_rd,
        output fifo_rd, pref_data, pref_valid, level, ovf_err
    );

    modport master (
        output flush, fifo_data, fifo_valid, fifo_empty, pref_rd,
        input  fifo_rd, pref_data, pref_valid, level, ovf_err
    );
endinterface

// File: rtl/shifter_prefetch_queue.sv
// Prefetch queue between an upstream FIFO (1-cycle read latency) and a shifter.
// Reads are issued against a credit of (queued + outstanding) < DEPTH, so the
// queue can never be pushed while full. A flush empties the queue and arms a
// drop counter that swallows reads still in flight.
// Optional feature: define SHIFTER_PREF_BYPASS_EN to let a word arriving into
// an empty queue be presented (and consumed) in its arrival cycle.
module shifter_prefetch_queue #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstN,
    shifter_prefetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [LW-1:0] outst_q, outst_d;
    logic [LW-1:0] drop_q, drop_d;
    logic          ovf_q, ovf_d;

    logic [LW:0]   credit_s;
    logic          fifo_rd_s;
    logic          valid_ok_s;
    logic          keep_s;
    logic          q_empty_s;
    logic          bypass_s;
    logic [DW-1:0] byp_data_s;
    logic          pref_valid_s;
    logic [DW-1:0] pref_data_s;
    logic          pop_s;
    logic          deq_s;
    logic          push_s;

    // Read credit and classification of the word returning this cycle
    always_comb begin
        credit_s   = {1'b0, count_q} + {1'b0, outst_q};
        fifo_rd_s  = rstN & ~bus.fifo_empty & ~bus.flush & (credit_s < (LW+1)'(DEPTH));
        valid_ok_s = bus.fifo_valid & (outst_q != {LW{1'b0}});
        keep_s     = valid_ok_s & (drop_q == {LW{1'b0}}) & ~bus.flush;
    end

    // Head-of-queue presentation; the bypass path only exists when enabled
    always_comb begin
        q_empty_s = (count_q == {LW{1'b0}});
`ifdef SHIFTER_PREF_BYPASS_EN
        bypass_s   = rstN & q_empty_s & keep_s;
        byp_data_s = bus.fifo_data;
`else
        bypass_s   = 1'b0;
        byp_data_s = {DW{1'b0}};
`endif
        pref_valid_s = rstN & ~bus.flush & (~q_empty_s | bypass_s);
        if (!pref_valid_s) begin
            pref_data_s = {DW{1'b0}};
        end else if (bypass_s) begin
            pref_data_s = byp_data_s;
        end else begin
            pref_data_s = mem_q[rd_ptr_q];
        end
    end

    // Next state for pointers, count, outstanding/drop tracking and error flag
    always_comb begin
        pop_s  = bus.pref_rd & pref_valid_s;
        deq_s  = pop_s & ~q_empty_s;
        push_s = keep_s & ~(bypass_s & bus.pref_rd);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        outst_d  = outst_q + LW'(fifo_rd_s) - LW'(valid_ok_s);
        // a return with nothing outstanding is a protocol error, never cleared
        ovf_d    = ovf_q | (bus.fifo_valid & ~valid_ok_s);

        if (bus.flush) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {LW{1'b0}};
            // every read not returning right now must be swallowed later
            drop_d   = outst_q - LW'(valid_ok_s);
        end else begin
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = count_q + LW'(push_s) - LW'(deq_s);
            if (valid_ok_s && (drop_q != {LW{1'b0}})) begin
                drop_d = drop_q - LW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {LW{1'b0}};
            outst_q  <= {LW{1'b0}};
            drop_q   <= {LW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Queue storage; entries are only visible through count, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus.fifo_data;
        end
    end

    assign bus.fifo_rd    = fifo_rd_s;
    assign bus.pref_valid = pref_valid_s;
    assign bus.pref_data  = pref_data_s;
    assign bus.level      = count_q;
    assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_shifter_prefetch_queue.sv
// Bench for shifter_prefetch_queue: directed scenarios followed by a random
// phase, every cycle compared against a queue-based reference model.
module tb_shifter_prefetch_queue;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rstN;

    shifter_prefetch_queue_if #(.DW(DW), .DEPTH(DEPTH)) dif ();

    shifter_prefetch_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (dif.slave)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] src[$];      // upstream FIFO contents
    logic [31:0] mq[$];       // reference prefetch queue
    int          m_out;       // reads issued, not yet returned
    int          m_drop;      // returns still to be discarded after a flush
    bit          m_ovf;
    bit          ret_vld;
    logic [31:0] ret_data;
    bit          last_rd;
    int          rd_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input logic [31:0] w);
        src.push_back(w);
        dif.fifo_empty = 1'b0;
    endtask

    // One clock: compare outputs with the model, advance model and upstream.
    task automatic cycle();
        bit          valid_ok, byp, e_rd, e_pv, pop, rd_now;
        logic [31:0] e_pd;
        #1;
        valid_ok = dif.fifo_valid && (m_out > 0);
        byp = 1'b0;
`ifdef SHIFTER_PREF_BYPASS_EN
        byp = !dif.flush && (mq.size() == 0) && valid_ok && (m_drop == 0);
`endif
        e_rd = !dif.fifo_empty && !dif.flush && ((mq.size() + m_out) < DEPTH);
        e_pv = !dif.flush && ((mq.size() != 0) || byp);
        if (!e_pv)               e_pd = 32'h0;
        else if (mq.size() != 0) e_pd = mq[0];
        else                     e_pd = dif.fifo_data;

        chk("fifo_rd",    32'(dif.fifo_rd),    32'(e_rd));
        chk("pref_valid", 32'(dif.pref_valid), 32'(e_pv));
        chk("pref_data",  dif.pref_data,       e_pd);
        chk("level",      32'(dif.level),      32'(mq.size()));
        chk("ovf_err",    32'(dif.ovf_err),    32'(m_ovf));

        rd_now  = dif.fifo_rd;
        last_rd = rd_now;
        pop     = dif.pref_rd && e_pv;
        if (dif.fifo_valid && (m_out == 0)) m_ovf = 1'b1;
        if (dif.flush) begin
            mq.delete();
            m_drop = m_out - (valid_ok ? 1 : 0);
        end else begin
            if (pop && (mq.size() != 0)) void'(mq.pop_front());
            if (valid_ok) begin
                if (m_drop > 0)        m_drop--;
                else if (!(byp && pop)) mq.push_back(dif.fifo_data);
            end
        end
        if (valid_ok) m_out--;
        if (e_rd)     m_out++;

        @(posedge clk);
        #1;
        ret_vld = rd_now && (src.size() > 0);
        if (ret_vld) ret_data = src.pop_front();
        dif.fifo_valid = ret_vld;
        dif.fifo_data  = ret_vld ? ret_data : $urandom;
        dif.fifo_empty = (src.size() == 0);
    endtask

    // Reset block and upstream together; caller preloads src beforehand.
    task automatic do_reset();
        rstN           = 1'b0;
        ret_vld        = 1'b0;
        dif.fifo_valid = 1'b0;
        dif.pref_rd    = 1'b0;
        dif.flush      = 1'b0;
        dif.fifo_empty = (src.size() == 0);
        mq.delete();
        m_out  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_fifo_rd",    32'(dif.fifo_rd),    32'h0);
        chk("rst_pref_valid", 32'(dif.pref_valid), 32'h0);
        chk("rst_pref_data",  dif.pref_data,       32'h0);
        chk("rst_level",      32'(dif.level),      32'h0);
        chk("rst_ovf_err",    32'(dif.ovf_err),    32'h0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        dif.flush      = 1'b0;
        dif.pref_rd    = 1'b0;
        dif.fifo_valid = 1'b0;
        dif.fifo_data  = 32'h0;
        dif.fifo_empty = 1'b1;
        rstN           = 1'b1;
        #1;

        // Release with three words waiting and no consumer
        src.delete();
        src.push_back(32'h11); src.push_back(32'h22); src.push_back(32'h33);
        do_reset();
        rd_cnt = 0;
        repeat (5) begin cycle(); rd_cnt += int'(last_rd); end
        #1;
        chk("boot_rd_pulses", 32'(rd_cnt),    32'd3);
        chk("boot_level",     32'(dif.level), 32'd3);
        chk("boot_head",      dif.pref_data,  32'h11);

        // Fill to full with ten words available
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(32'h1000 + 32'(i));
        do_reset();
        rd_cnt = 0;
        repeat (12) begin cycle(); rd_cnt += int'(last_rd); end
        #1;
        chk("full_rd_pulses", 32'(rd_cnt),      32'd4);
        chk("full_level",     32'(dif.level),   32'd4);
        chk("full_no_rd",     32'(dif.fifo_rd), 32'd0);

        // Continuous consumption: one word per cycle in order
        dif.pref_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stream_valid", 32'(dif.pref_valid), 32'd1);
            chk("stream_data",  dif.pref_data,       32'h1000 + 32'(i));
            if (i >= 2) chk("stream_level", 32'(dif.level), 32'd2);
            cycle();
        end
        repeat (3) cycle();

        // A single word returning into an empty queue with the consumer ready
        src.delete();
        do_reset();
        repeat (2) cycle();
        push_src(32'hA5A5_A5A5);
        dif.pref_rd = 1'b1;
        cycle();
        #1;
`ifdef SHIFTER_PREF_BYPASS_EN
        chk("byp_same_valid", 32'(dif.pref_valid), 32'd1);
        chk("byp_same_data",  dif.pref_data,       32'hA5A5_A5A5);
`else
        chk("byp_same_valid", 32'(dif.pref_valid), 32'd0);
`endif
        cycle();
        #1;
`ifdef SHIFTER_PREF_BYPASS_EN
        chk("byp_next_level", 32'(dif.level),      32'd0);
        chk("byp_next_valid", 32'(dif.pref_valid), 32'd0);
`else
        chk("byp_next_level", 32'(dif.level),      32'd1);
        chk("byp_next_valid", 32'(dif.pref_valid), 32'd1);
        chk("byp_next_data",  dif.pref_data,       32'hA5A5_A5A5);
`endif
        cycle();
        #1;
        chk("byp_end_level", 32'(dif.level), 32'd0);

        // Flush with two queued words and one read returning
        dif.pref_rd = 1'b0;
        src.delete();
        src.push_back(32'h100); src.push_back(32'h101); src.push_back(32'h102);
        src.push_back(32'h200); src.push_back(32'h201);
        do_reset();
        repeat (3) cycle();
        #1;
        chk("flush_pre_level", 32'(dif.level), 32'd2);
        dif.flush = 1'b1;
        cycle();
        dif.flush = 1'b0;
        #1;
        chk("flush_level", 32'(dif.level),      32'd0);
        chk("flush_valid", 32'(dif.pref_valid), 32'd0);
        cycle();
        cycle();
        #1;
        chk("flush_next_valid", 32'(dif.pref_valid), 32'd1);
        chk("flush_next_data",  dif.pref_data,       32'h200);

        // Spurious return with nothing outstanding
        repeat (3) cycle();
        #1;
        dif.fifo_valid = 1'b1;
        dif.fifo_data  = 32'hDEAD_BEEF;
        cycle();
        #1;
        chk("ovf_set",   32'(dif.ovf_err), 32'd1);
        chk("ovf_level", 32'(dif.level),   32'd2);
        repeat (4) cycle();
        #1;
        chk("ovf_sticky", 32'(dif.ovf_err), 32'd1);

        // Random traffic with a reset in the middle of the stream
        for (int i = 0; i < 400; i++) begin
            if (i == 250) begin
                src.delete();
                do_reset();
            end
            dif.pref_rd = ($urandom_range(0, 3) != 0);
            dif.flush   = ($urandom_range(0, 19) == 0);
            if ((src.size() < 4) && ($urandom_range(0, 1) == 1)) push_src($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
